ps2_host_tx: RTL and testbench

//   PS/2 host-to-device transmitter; the send-side counterpart of the keyboard scancode receiver.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 58 +++++
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter.
//   ps2_state_e  - transmitter FSM states
//   PS2_CMD_*    - common host command bytes, PS2_RSP_ACK - device acknowledge byte
//   odd_parity() - PS/2 frame parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

  // Watchdog counter width; must hold the largest supported timeout.
  localparam int WD_W = 20;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: double-flop synchronisers for the raw PS/2 clock and data
// lines plus a registered strobe on each falling edge of the synced clock.
//   clk, rst   - system clock, asynchronous active-high reset
//   scl_in     - raw PS/2 clock line (asynchronous)
//   sda_in     - raw PS/2 data line (asynchronous)
//   scl_sync   - synchronised clock line
//   sda_sync   - synchronised data line
//   scl_fall   - one-cycle strobe, high the cycle after scl_sync drops 1->0
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_sync,
  output logic sda_sync,
  output logic scl_fall
);

  logic scl_meta_q, scl_meta_d;
  logic scl_sync_q, scl_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic sda_meta_q, sda_meta_d;
  logic sda_sync_q, sda_sync_d;
  logic fall_q, fall_d;

  always_comb begin
    scl_meta_d = scl_in;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = sda_in;
    sda_sync_d = sda_meta_q;
    fall_d     = scl_prev_q & ~scl_sync_q;
  end

  // Idle bus level is high; resetting to 1 avoids a false fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      fall_q     <= fall_d;
    end
  end

  assign scl_sync = scl_sync_q;
  assign sda_sync = sda_sync_q;
  assign scl_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sequence: inhibit (SCL low), request-to-send (SCL+SDA low), release SCL,
// shift 8 data bits + odd parity + stop on device-generated clock falls,
// then sample the device ACK on the 11th fall and wait for an idle bus.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog on device clocking.
//
// Handshake: a byte is taken on any CLK edge where TX_VALID and TX_READY are
// both high; TX_READY is high only in IDLE, and TX_VALID at any other time is
// ignored, not queued.
//
// Ports:
//   CLK, RST   - system clock, asynchronous active-high reset
//   TX_DATA    - command byte, TX_VALID - send request, TX_READY - idle
//   SCL_IN     - raw clock line, SDA_IN - raw data line
//   SCL_OE     - 1 pulls SCL low, SDA_OE - 1 pulls SDA low (registered)
//   BUSY       - transmission in progress
//   TX_DONE    - one-cycle pulse, frame acknowledged
//   TX_ERR     - one-cycle pulse, NACK or watchdog timeout
//   dbg_state  - current FSM state
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SCL_OE,
  output logic       SDA_OE,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  output ps2_state_e dbg_state
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  if (INHIBIT_CYCLES < 1 || RTS_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << WD_W)) begin : g_bad_param
    $error("ps2_host_tx: cycle parameter out of range");
  end

  logic scl_sync, sda_sync, scl_fall;

  ps2_line_sync u_sync (
    .clk      (CLK),
    .rst      (RST),
    .scl_in   (SCL_IN),
    .sda_in   (SDA_IN),
    .scl_sync (scl_sync),
    .sda_sync (sda_sync),
    .scl_fall (scl_fall)
  );

  ps2_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             nack_q, nack_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic             done, err;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    par_d    = par_q;
    nack_d   = nack_q;
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        if (TX_VALID) begin
          data_d   = TX_DATA;
          par_d    = odd_parity(TX_DATA);
          tmr_d    = '0;
          scl_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (tmr_q == TMR_W'(INHIBIT_CYCLES - 1)) begin
          tmr_d    = '0;
          sda_oe_d = 1'b1;  // start bit
          state_d  = ST_RTS;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_RTS: begin
        if (tmr_q == TMR_W'(RTS_CYCLES - 1)) begin
          scl_oe_d = 1'b0;  // hand the clock to the device
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // Device samples on rising SCL, so the next bit is placed after each fall.
        if (scl_fall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q < 4'd8) begin
            sda_oe_d = ~data_q[cnt_q[2:0]];
          end else if (cnt_q == 4'd8) begin
            sda_oe_d = ~par_q;
          end else begin
            sda_oe_d = 1'b0;  // stop bit: release the line
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (scl_fall) begin
          nack_d  = sda_sync;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (scl_sync && sda_sync) begin
          done    = ~nack_q;
          err     = nack_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q;
    if ((state_q == ST_RTS && state_d == ST_SHIFT) || scl_fall) begin
      wd_d = '0;
    end else if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
      wd_d = wd_q + 1'b1;
    end
    // A normal completion in the same cycle wins, so DONE and ERR never coincide.
    if ((state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) &&
        state_d != ST_IDLE && wd_q == WD_LAST) begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      err      = 1'b1;
      state_d  = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      nack_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      par_q    <= par_d;
      nack_q   <= nack_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign TX_READY  = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign SCL_OE    = scl_oe_q;
  assign SDA_OE    = sda_oe_q;
  assign TX_DONE   = done;
  assign TX_ERR    = err;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a PS/2 device model on
// open-drain (wired-AND) lines. The device clock half period is H CLK cycles.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int H      = 20;
  localparam int TO_CYC = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, scl_oe, sda_oe, busy, tx_done, tx_err;
  ps2_state_e dbg_state;

  logic dev_scl_low = 1'b0;
  logic dev_sda_low = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = ~scl_oe & ~dev_scl_low;
  assign sda_line = ~sda_oe & ~dev_sda_low;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (5000),
    .RTS_CYCLES     (50),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .TX_DATA   (tx_data),
    .TX_VALID  (tx_valid),
    .TX_READY  (tx_ready),
    .SCL_IN    (scl_line),
    .SDA_IN    (sda_line),
    .SCL_OE    (scl_oe),
    .SDA_OE    (sda_oe),
    .BUSY      (busy),
    .TX_DONE   (tx_done),
    .TX_ERR    (tx_err),
    .dbg_state (dbg_state)
  );

  // ---------------- monitors ----------------
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0, ready_bad = 0;
  always @(negedge clk) begin
    if (!rst) begin
      done_cnt += int'(tx_done);
      err_cnt  += int'(tx_err);
      if (tx_done && tx_err) both_cnt++;
      if (scl_oe && !sda_oe) inh_cnt++;
      if (scl_oe && sda_oe) rts_cnt++;
      if (tx_ready == busy) ready_bad++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_tx(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (!tx_ready && k < 20000) begin @(negedge clk); k++; end
    if (k >= 20000) fail_bound("start_tx_ready");
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Request-to-send is complete once SCL is released while SDA is held low.
  task automatic wait_rts_release(output bit ok);
    int k = 0;
    while (!(scl_line && !sda_line) && k < 20000) begin @(negedge clk); k++; end
    ok = (k < 20000);
    if (!ok) fail_bound("wait_rts_release");
  endtask

  // Device side: clock out n_falls falls (10 = full frame), sampling SDA on each
  // rising edge; bits[0] is the start bit. With a full frame, optionally ACK.
  task automatic dev_frame(input int n_falls, input bit do_ack, output logic [10:0] bits);
    bit ok;
    bits = '0;
    wait_rts_release(ok);
    if (!ok) return;
    repeat (H) @(negedge clk);
    bits[0] = sda_line;
    for (int i = 1; i <= 10; i++) begin
      dev_scl_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i == n_falls && n_falls < 10) return;
      dev_scl_low = 1'b0;
      bits[i] = sda_line;
      repeat (H) @(negedge clk);
    end
    if (do_ack) dev_sda_low = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_scl_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_scl_low = 1'b0;
    repeat (H) @(negedge clk);
    dev_sda_low = 1'b0;
  endtask

  task automatic wait_not_busy(input string name);
    int k = 0;
    while (busy && k < 1000) begin @(negedge clk); k++; end
    if (k >= 1000) fail_bound(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] exp_frame;  // {stop, parity, data[7:0], start} as sampled by the device
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [10:0] bits, bits2;
    int d0, e0, i0, r0, k;
    bit ok;

    // 0xED: 1,0,1,1,0,1,1,1 LSB first, six ones -> parity 1
    vecs[0] = '{PS2_CMD_SETLED, 1'b1, 11'h7DA, 1, 0};
    // 0xF4: 0,0,1,0,1,1,1,1, five ones -> parity 0
    vecs[1] = '{PS2_CMD_ENABLE, 1'b1, 11'h5E8, 1, 0};
    // 0x00 with no ACK from the device -> error
    vecs[2] = '{8'h00,          1'b0, 11'h600, 0, 1};
    // 0xFF: eight ones -> parity 1
    vecs[3] = '{PS2_CMD_RESET,  1'b1, 11'h7FE, 1, 0};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_scl_oe",   scl_oe,   0);
    check("rst_sda_oe",   sda_oe,   0);
    check("rst_ready",    tx_ready, 1);
    check("rst_busy",     busy,     0);
    check("rst_done",     tx_done,  0);
    check("rst_err",      tx_err,   0);
    check("rst_state",    dbg_state, ST_IDLE);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // ---- table-driven full frames ----
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rts_cnt;
      start_tx(vecs[v].data);
      dev_frame(10, vecs[v].ack, bits);
      wait_not_busy("frame_end");
      @(negedge clk);
      check($sformatf("v%0d_frame", v),   bits,              vecs[v].exp_frame);
      check($sformatf("v%0d_done", v),    done_cnt - d0,     vecs[v].exp_done);
      check($sformatf("v%0d_err", v),     err_cnt - e0,      vecs[v].exp_err);
      check($sformatf("v%0d_inhibit", v), inh_cnt - i0,      5000);
      check($sformatf("v%0d_rts", v),     rts_cnt - r0,      50);
      check($sformatf("v%0d_ready", v),   tx_ready,          1);
      check($sformatf("v%0d_scl_oe", v),  scl_oe,            0);
      check($sformatf("v%0d_sda_oe", v),  sda_oe,            0);
    end

    // ---- device never clocks after release ----
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h55);
    wait_rts_release(ok);
`ifdef PS2_TX_TIMEOUT_EN
    k = 0;
    while (busy && k < TO_CYC + 200) begin @(negedge clk); k++; end
    if (k >= TO_CYC + 200) fail_bound("timeout_wait");
    check("timeout_latency", (k >= TO_CYC - 10) && (k <= TO_CYC + 10), 1);
    check("timeout_err",    err_cnt - e0,  1);
    check("timeout_done",   done_cnt - d0, 0);
    check("timeout_scl_oe", scl_oe,        0);
    check("timeout_sda_oe", sda_oe,        0);
    check("timeout_ready",  tx_ready,      1);
`else
    repeat (3 * TO_CYC) @(negedge clk);
    check("stall_busy",   busy,          1);
    check("stall_state",  dbg_state,     ST_SHIFT);
    check("stall_sda_oe", sda_oe,        1);
    check("stall_err",    err_cnt - e0,  0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
`endif

    // ---- reset during data bit 4 releases lines without a clock edge ----
    start_tx(PS2_CMD_SETLED);
    dev_frame(5, 1'b0, bits);
    check("midrst_pre_sda_oe", sda_oe, 1);  // bit 4 of 0xED is 0
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_scl_oe", scl_oe,   0);
    check("midrst_sda_oe", sda_oe,   0);
    check("midrst_ready",  tx_ready, 1);
    check("midrst_busy",   busy,     0);
    dev_scl_low = 1'b0;
    dev_sda_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // ---- TX_VALID held with 0xAA during a 0xED frame ----
    d0 = done_cnt; e0 = err_cnt;
    start_tx(PS2_CMD_SETLED);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    dev_frame(10, 1'b1, bits);
    check("hold_first_frame", bits, 11'h7DA);
    k = 0;
    while (done_cnt - d0 < 1 && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) fail_bound("hold_first_done");
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) fail_bound("hold_reaccept");
    tx_valid = 1'b0;
    dev_frame(10, 1'b1, bits2);
    wait_not_busy("hold_second_end");
    @(negedge clk);
    // 0xAA: 0,1,0,1,0,1,0,1, four ones -> parity 1
    check("hold_second_frame", bits2,         11'h754);
    check("hold_done",         done_cnt - d0, 2);
    check("hold_err",          err_cnt - e0,  0);

    check("done_err_overlap", both_cnt,  0);
    check("ready_vs_busy",    ready_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
